idli_ifb_m: RTL
===============

Name: idli_ifb_m

Overview:
- Instruction fetch buffer; sits directly downstream of idli_sqi_m.
- Reassembles the 4-bit-per-cycle SQI read stream into 16-bit instruction words, tagged with their word address.
- Buffers the words and replays them to decode one slice per cycle, aligned to the shared 2-bit counter.
- Owns the fetch PC. Requests SQI redirects on branch or on overflow (replay), serially presenting the target address.

Parameters:
- DEPTH, 2, number of {pc, word} entries buffered (power of two, ≥2).

Ports:
- i_ifb_gck  in  1  core clock
- i_ifb_rst_n  in  1  reset
- i_ifb_ctr  in  2 (ctr_t)  slice counter; slice k of a word is transferred when ctr==k
- i_ifb_sqi_data  in  4 (slice_t)  read slice from SQI
- i_ifb_sqi_data_vld  in  1  SQI slice valid
- o_ifb_sqi_redirect  out  1  redirect request to SQI, held for ctr 0..3
- o_ifb_sqi_addr  out  4 (slice_t)  redirect target word address, slice ctr of the address
- i_ifb_br_taken  in  1  branch from execute, sampled at ctr==0
- i_ifb_br_pc  in  4 (slice_t)  branch target slice, ctr 0..3 of that same word
- i_ifb_dec_ack  in  1  decode consumes current word, sampled at ctr==3
- o_ifb_dec_vld  out  1  decode word valid, constant over ctr 0..3
- o_ifb_dec_data  out  4 (slice_t)  instruction slice ctr of head entry
- o_ifb_dec_pc  out  4 (slice_t)  PC slice ctr of head entry

Behaviour:
- Reset and clocking:
  - One clock; reset is asynchronous and active-low.
  - Reset values: all outputs 0, FIFO empty, fpc = 0x0000, state RUN, replay-pending 0.
  - Reset mid-operation forces these values immediately, including mid-word and mid-redirect.
- Ordering: all 16-bit quantities are transferred LSB slice first, so slice k = bits [4k+3:4k].
- Assembly:
  - Starts at ctr==0 with vld=1.
  - If vld drops before ctr==3, the partial word is discarded; fpc is unchanged.
  - At ctr==3, a complete word is pushed as {fpc, word}, then fpc increments, wrapping 0xFFFF→0x0000.
  - Words arriving outside state RUN, or while replay-pending, are ignored; fpc is not incremented.
- Overflow:
  - A complete word that arrives when the FIFO is full (after this cycle's pop) is dropped.
  - On a drop, set replay-pending and hold fpc at the dropped word's address.
  - At the next ctr==0, go to REDIRECT with target fpc and clear replay-pending.
- Branch:
  - i_ifb_br_taken=1 at ctr==0 in any state: flush the FIFO and the assembly register, cancel replay-pending, and abort any in-progress REDIRECT (outputs go 0).
  - Go to CAPTURE and shift i_ifb_br_pc into fpc over ctr 0..3.
  - Then go to REDIRECT at the next ctr==0. Branch has priority over replay.
- States and transitions:
  - RUN → REDIRECT on replay at ctr==0.
  - Any state → CAPTURE on branch at ctr==0.
  - CAPTURE → REDIRECT at ctr==0.
  - REDIRECT drives o_ifb_sqi_redirect=1 and o_ifb_sqi_addr = fpc slice for exactly ctr 0..3, then goes to RUN.
  - The first valid word after that is fetched from fpc.
- Decode:
  - o_ifb_dec_vld is latched at ctr==0 as FIFO non-empty, and held for the whole word.
  - Head slices are presented combinationally from the head entry by ctr.
  - Pop at ctr==3 if ack && dec_vld. An ack without dec_vld is ignored.
  - A branch asserted in the same word as an ack: the flush wins and the FIFO ends empty.
- Simultaneous push and pop at ctr==3 when full: pop first, the push succeeds, and no replay occurs.
- Assertions:
  - ctr increments by 1 every cycle.
  - FIFO count never exceeds DEPTH.
  - No redirect while in CAPTURE.

Decomposition:
- idli_pkg:
  - word_t (16-bit)
  - ifb_state_t enum {RUN, CAPTURE, REDIRECT}
  - ifb_entry_t {pc, word}
  - IFB_DEPTH_DEFAULT
- Sub-module idli_ifb_fifo_m: parametric DEPTH circular buffer of ifb_entry_t with push, pop, flush, full and empty signals, and pop-before-push full evaluation.
- The state machine, assembly and serialisation stay in idli_ifb_m.

Test Plan:
- Reset, then SQI streams 0x1234 and 0xABCD with vld, ack held 1 → dec_vld on the following words; data slices 4,3,2,1 then D,C,B,A; dec_pc slices give 0x0000 then 0x0001.
- ack=0, three words at addresses 0,1,2 (DEPTH=2) → word 2 dropped; redirect at the next ctr 0..3 with addr slices 2,0,0,0; later words ignored until the redirect completes; after acks, the word tagged pc 0x0002 is delivered.
- br_taken at ctr==0 with br_pc slices 0,3,F,0 while FIFO holds 2 words → dec_vld=0 at the next word; redirect slices 0,3,F,0; the next delivered entry has pc 0x0F30.
- FIFO full, ack at ctr==3 together with a word completing → no drop, no redirect, count stays 2, order preserved.
- vld falls at ctr==2 → no push; fpc unchanged; the next full word is tagged with the same pc.
- rst_n pulsed low during REDIRECT at ctr==1 → redirect, addr and dec outputs are 0 immediately; the first word after release is tagged pc 0x0000.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared types for the idli fetch path: slice/counter aliases, the fetch
// buffer state encoding and the {pc, word} entry held by the fetch FIFO.
package idli_pkg;

    typedef logic [1:0]  ctr_t;
    typedef logic [3:0]  slice_t;
    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        CAPTURE  = 2'd1,
        REDIRECT = 2'd2
    } ifb_state_t;

    typedef struct packed {
        word_t pc;
        word_t word;
    } ifb_entry_t;

    localparam int IFB_DEPTH_DEFAULT = 2;

    // Slice k of a 16-bit quantity; slices travel LSB first.
    function automatic slice_t slice_of(input word_t w, input ctr_t k);
        return w[{k, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/idli_ifb_fifo_m.sv
// Circular buffer of {pc, word} entries for the fetch buffer. A pop in the
// same cycle as a push frees the slot first, so a full FIFO can still
// accept a word while its head is being consumed.
module idli_ifb_fifo_m
    import idli_pkg::*;
#(
    parameter int DEPTH = IFB_DEPTH_DEFAULT
)
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  ifb_entry_t               entry_i,
    input  logic                     pop_i,
    output ifb_entry_t               head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ifb_entry_t     mem_q [DEPTH];
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [CW-1:0]  count_q, count_d;
    logic           pushOk;
    logic           popOk;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];
    assign popOk   = pop_i && !empty_o;
    assign pushOk  = push_i && (!full_o || popOk);

    // Pointer and occupancy update; flush discards everything at once.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (popOk) begin
                rd_d = rd_q + AW'(1);
            end
            if (pushOk) begin
                wr_d = wr_q + AW'(1);
            end
            count_d = count_q + CW'(pushOk) - CW'(popOk);
        end
    end

    // Pointer registers, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (pushOk && !flush_i) begin
            mem_q[wr_q] <= entry_i;
        end
    end

    countInRange: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CW'(DEPTH));

endmodule

// File: rtl/idli_ifb_m.sv
// Instruction fetch buffer: rebuilds 16-bit words from the 4-bit SQI stream,
// tags them with the fetch PC, buffers them and replays them to decode one
// slice per cycle. Owns the fetch PC and asks the SQI to redirect on a
// branch or when a word had to be dropped because the buffer was full.
module idli_ifb_m
    import idli_pkg::*;
#(
    parameter int DEPTH = IFB_DEPTH_DEFAULT
)
(
    input  logic   i_ifb_gck,
    input  logic   i_ifb_rst_n,
    input  ctr_t   i_ifb_ctr,
    input  slice_t i_ifb_sqi_data,
    input  logic   i_ifb_sqi_data_vld,
    output logic   o_ifb_sqi_redirect,
    output slice_t o_ifb_sqi_addr,
    input  logic   i_ifb_br_taken,
    input  slice_t i_ifb_br_pc,
    input  logic   i_ifb_dec_ack,
    output logic   o_ifb_dec_vld,
    output slice_t o_ifb_dec_data,
    output slice_t o_ifb_dec_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifb_state_t    state_q, state_d;
    word_t         fpc_q, fpc_d;
    logic          replay_q, replay_d;
    logic [11:0]   asm_q, asm_d;
    logic          asmValid_q, asmValid_d;
    logic          decVld_q, decVld_d;

    logic          ctrFirst, ctrLast, branch;
    logic          wordDone, pushReq, pushOk, pop, drop;
    ifb_entry_t    head;
    logic          fifoFull, fifoEmpty;
    logic [CW-1:0] fifoCount;

    assign ctrFirst = (i_ifb_ctr == 2'd0);
    assign ctrLast  = (i_ifb_ctr == 2'd3);
    assign branch   = ctrFirst && i_ifb_br_taken;

    // Word-boundary state decision; state_d is the state of the current word.
    always_comb begin
        state_d = state_q;
        if (branch) begin
            state_d = CAPTURE;
        end else if (ctrFirst) begin
            unique case (state_q)
                CAPTURE:  state_d = REDIRECT;
                REDIRECT: state_d = RUN;
                default:  state_d = replay_q ? REDIRECT : RUN;
            endcase
        end
    end

    // Slice assembly; any gap in valid before the last slice loses the word.
    always_comb begin
        asm_d      = asm_q;
        asmValid_d = asmValid_q;
        unique case (i_ifb_ctr)
            2'd0: begin
                asm_d[3:0] = i_ifb_sqi_data;
                asmValid_d = i_ifb_sqi_data_vld && !branch;
            end
            2'd1: begin
                asm_d[7:4] = i_ifb_sqi_data;
                asmValid_d = asmValid_q && i_ifb_sqi_data_vld;
            end
            2'd2: begin
                asm_d[11:8] = i_ifb_sqi_data;
                asmValid_d  = asmValid_q && i_ifb_sqi_data_vld;
            end
            default: begin
                asmValid_d = 1'b0;
            end
        endcase
    end

    assign wordDone = ctrLast && asmValid_q && i_ifb_sqi_data_vld;
    assign pushReq  = wordDone && (state_d == RUN) && !replay_q;
    assign pop      = ctrLast && i_ifb_dec_ack && decVld_q && !fifoEmpty;
    assign drop     = pushReq && fifoFull && !pop;
    assign pushOk   = pushReq && !drop;

    // Fetch PC, replay flag and decode-valid next values.
    always_comb begin
        fpc_d    = fpc_q;
        replay_d = replay_q;
        decVld_d = decVld_q;
        if (state_d == CAPTURE) begin
            fpc_d = {i_ifb_br_pc, fpc_q[15:4]};
        end else if (pushOk) begin
            fpc_d = fpc_q + 16'd1;
        end
        if (ctrFirst && (state_d != RUN)) begin
            replay_d = 1'b0;
        end else if (drop) begin
            replay_d = 1'b1;
        end
        if (ctrLast) begin
            decVld_d = ((fifoCount + CW'(pushOk) - CW'(pop)) != '0);
        end
    end

    // Control and datapath registers, all forced to idle by reset.
    always_ff @(posedge i_ifb_gck or negedge i_ifb_rst_n) begin
        if (!i_ifb_rst_n) begin
            state_q    <= RUN;
            fpc_q      <= '0;
            replay_q   <= 1'b0;
            asm_q      <= '0;
            asmValid_q <= 1'b0;
            decVld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            replay_q   <= replay_d;
            asm_q      <= asm_d;
            asmValid_q <= asmValid_d;
            decVld_q   <= decVld_d;
        end
    end

    idli_ifb_fifo_m #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (i_ifb_gck),
        .rst_ni  (i_ifb_rst_n),
        .flush_i (branch),
        .push_i  (pushReq),
        .entry_i ('{pc: fpc_q, word: {i_ifb_sqi_data, asm_q}}),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    assign o_ifb_sqi_redirect = (state_d == REDIRECT);
    assign o_ifb_sqi_addr     = o_ifb_sqi_redirect ? slice_of(fpc_q, i_ifb_ctr) : '0;
    assign o_ifb_dec_vld      = decVld_q;
    assign o_ifb_dec_data     = decVld_q ? slice_of(head.word, i_ifb_ctr) : '0;
    assign o_ifb_dec_pc       = decVld_q ? slice_of(head.pc, i_ifb_ctr) : '0;

    ctrSteps: assert property (@(posedge i_ifb_gck) disable iff (!i_ifb_rst_n)
        i_ifb_ctr == ctr_t'($past(i_ifb_ctr) + 2'd1));

    noRedirectInCapture: assert property (@(posedge i_ifb_gck) disable iff (!i_ifb_rst_n)
        (state_d == CAPTURE) |-> !o_ifb_sqi_redirect);

endmodule
